frame_scanner: RTL and testbench

- Read side of the 1024-word display frame RAM that number_writer fills.
- Scans one 2-bit page of the RAM, 8 rows x 32 columns, one word per pixel.
- Shifts each row serially into the RGB LED matrix column drivers, then latches it and drives the row select.
- Sits between the frame RAM read port and the matrix connector pins.

---
 rtl/matrix_pkg.sv | 33 +++
 rtl/frame_scanner_concat.sv | 16 +
 rtl/frame_scanner.sv | 193 +++++++++++++++++++
 tb/tb_frame_scanner.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the LED matrix display path: scan geometry, colour bit
// positions, and the state encodings of both frame-RAM clients.
package matrix_pkg;

   localparam int MATRIX_ROWS = 8;
   localparam int MATRIX_COLS = 32;
   localparam int ROW_W       = $clog2(MATRIX_ROWS);
   localparam int COL_W       = $clog2(MATRIX_COLS);
   localparam int PAGE_W      = 2;

   localparam int RGB_R_BIT = 2;
   localparam int RGB_G_BIT = 1;
   localparam int RGB_B_BIT = 0;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      DATA    = 3'd2,
      CLK_HI  = 3'd3,
      BLANK   = 3'd4,
      LATCH   = 3'd5,
      DISPLAY = 3'd6
   } scan_state_t;

   // number_writer sequencer states (write side of the same frame RAM)
   typedef enum logic [1:0] {
      NW_IDLE  = 2'd0,
      NW_CLEAR = 2'd1,
      NW_WRITE = 2'd2,
      NW_DONE  = 2'd3
   } writer_state_t;

endpackage

// File: rtl/frame_scanner_concat.sv
// Forms a frame RAM address from page offset, row and column fields.
module frame_scanner_concat #(
   parameter int OFFSET_W = 2,
   parameter int ROW_W    = 3,
   parameter int COL_W    = 5,
   parameter int ADDR_W   = 10
) (
   input  logic [OFFSET_W-1:0] i_offset,
   input  logic [ROW_W-1:0]    i_row,
   input  logic [COL_W-1:0]    i_col,
   output logic [ADDR_W-1:0]   o_addr
);

   assign o_addr = ADDR_W'({i_offset, i_row, i_col});

endmodule

// File: rtl/frame_scanner.sv
// Reads one page of the frame RAM row by row, shifts each row into the matrix
// column drivers, latches it and holds it lit for HOLD_CYCLES.
module frame_scanner
   import matrix_pkg::*;
#(
   parameter int HOLD_CYCLES = 1024,
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [PAGE_W-1:0] page,
   input  logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_en,
   output logic              r,
   output logic              g,
   output logic              b,
   output logic              sclk,
   output logic              lat,
   output logic              oe_n,
   output logic [ROW_W-1:0]  row_sel,
   output logic              frame_done,
   output logic              busy
);

   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(MATRIX_ROWS - 1);
   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(MATRIX_COLS - 1);

   scan_state_t       r_state;
   logic [ROW_W-1:0]  r_row;
   logic [COL_W-1:0]  r_col;
   logic [PAGE_W-1:0] r_page_q;
   logic [HOLD_W-1:0] r_hold;

   logic [ADDR_W-1:0] r_rd_addr;
   logic              r_rd_en;
   logic              r_red;
   logic              r_grn;
   logic              r_blu;
   logic              r_sclk;
   logic              r_lat;
   logic              r_oe_n;
   logic [ROW_W-1:0]  r_row_sel;
   logic              r_frame_done;
   logic              r_busy;

   scan_state_t       w_state_next;
   logic [ROW_W-1:0]  w_row_next;
   logic [COL_W-1:0]  w_col_next;
   logic [PAGE_W-1:0] w_page_next;
   logic [HOLD_W-1:0] w_hold_next;
   logic              w_frame_end;
   logic [ADDR_W-1:0] w_addr_next;
   logic              w_unused;

   // Only the low colour bits of each word drive the matrix.
   assign w_unused = ^rd_data;

   always_comb begin
      w_state_next = r_state;
      w_row_next   = r_row;
      w_col_next   = r_col;
      w_page_next  = r_page_q;
      w_hold_next  = r_hold;
      w_frame_end  = 1'b0;
      case (r_state)
         IDLE: begin
            if (enable) begin
               w_page_next  = page;
               w_row_next   = '0;
               w_col_next   = '0;
               w_state_next = FETCH;
            end
         end
         FETCH:  w_state_next = DATA;
         DATA:   w_state_next = CLK_HI;
         CLK_HI: begin
            if (r_col == COL_LAST) begin
               w_col_next   = '0;
               w_state_next = BLANK;
            end else begin
               w_col_next   = r_col + COL_W'(1);
               w_state_next = FETCH;
            end
         end
         BLANK:  w_state_next = LATCH;
         LATCH: begin
            w_hold_next  = '0;
            w_state_next = DISPLAY;
         end
         DISPLAY: begin
            if (r_hold == HOLD_LAST) begin
               w_hold_next = '0;
               if (r_row != ROW_LAST) begin
                  w_row_next   = r_row + ROW_W'(1);
                  w_state_next = FETCH;
               end else begin
                  w_row_next  = '0;
                  w_frame_end = 1'b1;
                  if (enable) begin
                     w_page_next  = page;
                     w_state_next = FETCH;
                  end else begin
                     w_state_next = IDLE;
                  end
               end
            end else begin
               w_hold_next = r_hold + HOLD_W'(1);
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   frame_scanner_concat #(
      .OFFSET_W (PAGE_W),
      .ROW_W    (ROW_W),
      .COL_W    (COL_W),
      .ADDR_W   (ADDR_W)
   ) u_addr_concat (
      .i_offset (w_page_next),
      .i_row    (w_row_next),
      .i_col    (w_col_next),
      .o_addr   (w_addr_next)
   );

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_row        <= '0;
         r_col        <= '0;
         r_page_q     <= '0;
         r_hold       <= '0;
         r_rd_addr    <= '0;
         r_rd_en      <= 1'b0;
         r_red        <= 1'b0;
         r_grn        <= 1'b0;
         r_blu        <= 1'b0;
         r_sclk       <= 1'b0;
         r_lat        <= 1'b0;
         r_oe_n       <= 1'b1;
         r_row_sel    <= '0;
         r_frame_done <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_row        <= w_row_next;
         r_col        <= w_col_next;
         r_page_q     <= w_page_next;
         r_hold       <= w_hold_next;
         r_rd_en      <= (w_state_next == FETCH);
         r_sclk       <= (w_state_next == CLK_HI);
         r_lat        <= (w_state_next == LATCH);
         r_frame_done <= w_frame_end;
         r_busy       <= (w_state_next != IDLE);
         if (w_state_next == FETCH) begin
            r_rd_addr <= w_addr_next;
         end
         if (r_state == DATA) begin
            r_red <= rd_data[RGB_R_BIT];
            r_grn <= rd_data[RGB_G_BIT];
            r_blu <= rd_data[RGB_B_BIT];
         end
         if (w_state_next == LATCH) begin
            r_row_sel <= r_row;
         end
         // Shifting states leave oe_n alone so the previous row stays lit.
         case (w_state_next)
            IDLE, BLANK, LATCH: r_oe_n <= 1'b1;
            DISPLAY:            r_oe_n <= 1'b0;
            default:            r_oe_n <= r_oe_n;
         endcase
      end
   end

   assign rd_addr    = r_rd_addr;
   assign rd_en      = r_rd_en;
   assign r          = r_red;
   assign g          = r_grn;
   assign b          = r_blu;
   assign sclk       = r_sclk;
   assign lat        = r_lat;
   assign oe_n       = r_oe_n;
   assign row_sel    = r_row_sel;
   assign frame_done = r_frame_done;
   assign busy       = r_busy;

endmodule

// File: tb/tb_frame_scanner.sv
// Scoreboard bench for frame_scanner: stimulus queues expected reads, colours,
// latched rows and frame timing; monitors compare as the DUT presents them.
module tb_frame_scanner;
   import matrix_pkg::*;

   localparam int HOLD      = 4;
   localparam int ROW_CYC   = 96 + 2 + HOLD;
   localparam int FRAME_CYC = MATRIX_ROWS * ROW_CYC;
   localparam logic [21:0] RST_VEC = {10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0};

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [1:0]  page;
   logic [31:0] rd_data = '0;
   logic [9:0]  rd_addr;
   logic        rd_en;
   logic        r, g, b;
   logic        sclk;
   logic        lat;
   logic        oe_n;
   logic [2:0]  row_sel;
   logic        frame_done;
   logic        busy;

   always #5 clk = ~clk;

   frame_scanner #(
      .HOLD_CYCLES (HOLD),
      .DATA_W      (32),
      .ADDR_W      (10)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .page       (page),
      .rd_data    (rd_data),
      .rd_addr    (rd_addr),
      .rd_en      (rd_en),
      .r          (r),
      .g          (g),
      .b          (b),
      .sclk       (sclk),
      .lat        (lat),
      .oe_n       (oe_n),
      .row_sel    (row_sel),
      .frame_done (frame_done),
      .busy       (busy)
   );

   typedef struct {
      int gap;
      bit busy_after;
      bit oe_n_after;
   } fd_exp_t;

   logic [9:0] addr_q[$];
   logic [2:0] rgb_q[$];
   logic [2:0] row_q[$];
   fd_exp_t    fd_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   // Page 0 row 0 alternates 101/010 across columns; elsewhere colour = low address bits.
   function automatic logic [2:0] rgb_of(input logic [9:0] a);
      if (a[9:5] == 5'd0) return a[0] ? 3'b010 : 3'b101;
      return a[2:0];
   endfunction

   function automatic logic [31:0] ram_word(input logic [9:0] a);
      return {4'hA, 15'h5555, a, rgb_of(a)};
   endfunction

   function automatic logic [21:0] out_vec();
      return {rd_addr, rd_en, r, g, b, sclk, lat, oe_n, row_sel, frame_done, busy};
   endfunction

   always @(posedge clk) begin
      if (rd_en) rd_data <= ram_word(rd_addr);
   end

   task automatic push_frame(input logic [1:0] pg, input bit continues);
      fd_exp_t e;
      for (int row = 0; row < MATRIX_ROWS; row++) begin
         for (int col = 0; col < MATRIX_COLS; col++) begin
            logic [9:0] a;
            a = {pg, 3'(row), 5'(col)};
            addr_q.push_back(a);
            rgb_q.push_back(rgb_of(a));
         end
         row_q.push_back(3'(row));
      end
      e.gap        = FRAME_CYC;
      e.busy_after = continues;
      e.oe_n_after = !continues;
      fd_q.push_back(e);
   endtask

   task automatic wait_addr(input logic [9:0] a, input string nm);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(rd_en === 1'b1 && rd_addr === a) && n < 2 * FRAME_CYC);
      chk(nm, {22'd0, rd_addr}, {22'd0, a});
   endtask

   task automatic wait_busy(input logic lvl, input string nm);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy !== lvl && n < 2 * FRAME_CYC);
      chk(nm, {31'd0, busy}, {31'd0, lvl});
   endtask

   // Main monitor: reads, serial colours, latched rows, frame pacing.
   initial begin
      int cyc = 0;
      int ref_cyc = 0;
      logic prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rd_en === 1'b1) begin
            if (addr_q.size() == 0) chk("rd_en_unexpected", {31'd0, rd_en}, 32'd0);
            else chk("rd_addr", {22'd0, rd_addr}, {22'd0, addr_q.pop_front()});
         end
         if (sclk === 1'b1) begin
            if (rgb_q.size() == 0) chk("sclk_unexpected", {31'd0, sclk}, 32'd0);
            else chk("rgb", {29'd0, r, g, b}, {29'd0, rgb_q.pop_front()});
         end
         if (lat === 1'b1) begin
            $display("latch   t=%0t row_sel=%0d", $time, row_sel);
            if (row_q.size() == 0) chk("lat_unexpected", {31'd0, lat}, 32'd0);
            else chk("row_sel", {29'd0, row_sel}, {29'd0, row_q.pop_front()});
         end
         if (busy === 1'b1 && prev_busy === 1'b0 && frame_done !== 1'b1) ref_cyc = cyc;
         if (frame_done === 1'b1) begin
            $display("frame   t=%0t gap=%0d busy=%0b oe_n=%0b", $time, cyc - ref_cyc, busy, oe_n);
            if (fd_q.size() == 0) chk("frame_done_unexpected", {31'd0, frame_done}, 32'd0);
            else begin
               fd_exp_t e;
               e = fd_q.pop_front();
               chk("frame_gap", cyc - ref_cyc, e.gap);
               chk("frame_busy", {31'd0, busy}, {31'd0, e.busy_after});
               chk("frame_oe_n", {31'd0, oe_n}, {31'd0, e.oe_n_after});
            end
            ref_cyc = cyc;
         end
         prev_busy = busy;
      end
   end

   // Dwell monitor: oe_n low for exactly HOLD cycles after each latch.
   initial begin
      forever begin
         @(negedge clk);
         if (lat === 1'b1) begin
            bit ok = 1'b1;
            chk("lat_oe_n", {31'd0, oe_n}, 32'd1);
            for (int i = 0; i < HOLD; i++) begin
               @(negedge clk);
               if (oe_n !== 1'b0 || lat !== 1'b0) ok = 1'b0;
            end
            chk("dwell_oe_n_low", {31'd0, ok}, 32'd1);
            @(negedge clk);
            chk("dwell_end", {31'd0, rd_en | frame_done}, 32'd1);
         end
      end
   end

   initial begin
      int n_act;
      rst    = 1'b0;
      enable = 1'b1;
      page   = 2'd3;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {10'd0, out_vec()}, {10'd0, RST_VEC});

      enable = 1'b0;
      rst    = 1'b1;
      n_act  = 0;
      repeat (200) begin
         @(negedge clk);
         if (rd_en !== 1'b0 || busy !== 1'b0 || lat !== 1'b0) n_act++;
      end
      chk("idle_activity", n_act, 0);
      chk("idle_outputs", {10'd0, out_vec()}, {10'd0, RST_VEC});

      // Two frames: page change in row 3 applies to frame 2; enable drop in frame 2 row 4.
      push_frame(2'd1, 1'b1);
      push_frame(2'd2, 1'b0);
      page   = 2'd1;
      enable = 1'b1;
      wait_addr({2'd1, 3'd3, 5'd5}, "reach_f1_row3");
      page = 2'd2;
      wait_addr({2'd2, 3'd4, 5'd0}, "reach_f2_row4");
      enable = 1'b0;
      wait_busy(1'b0, "idle_after_f2");
      chk("idle_oe_n_busy", {30'd0, oe_n, busy}, 32'b10);

      // Page 0 single frame with alternating colours in row 0.
      push_frame(2'd0, 1'b0);
      page   = 2'd0;
      enable = 1'b1;
      wait_busy(1'b1, "start_f3");
      enable = 1'b0;
      wait_busy(1'b0, "idle_after_f3");

      // Asynchronous reset in the middle of shifting row 0.
      for (int col = 0; col < MATRIX_COLS; col++) begin
         addr_q.push_back({2'd3, 3'd0, 5'(col)});
         rgb_q.push_back(rgb_of({2'd3, 3'd0, 5'(col)}));
      end
      page   = 2'd3;
      enable = 1'b1;
      wait_addr({2'd3, 3'd0, 5'd17}, "reach_col17");
      #2;
      rst = 1'b0;
      #1;
      chk("async_reset_outputs", {10'd0, out_vec()}, {10'd0, RST_VEC});
      addr_q.delete();
      rgb_q.delete();
      repeat (2) @(negedge clk);
      chk("reset_hold_outputs", {10'd0, out_vec()}, {10'd0, RST_VEC});
      push_frame(2'd3, 1'b0);
      rst = 1'b1;
      wait_busy(1'b1, "restart_f4");
      enable = 1'b0;
      wait_busy(1'b0, "idle_after_f4");

      repeat (5) @(negedge clk);
      chk("addr_q_drained", addr_q.size(), 0);
      chk("rgb_q_drained", rgb_q.size(), 0);
      chk("row_q_drained", row_q.size(), 0);
      chk("fd_q_drained", fd_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
